// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: FSM states, framing bytes, CRC-32 constants.
package eth_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_DRAIN, S_IFG
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] PREAMBLE_LEN  = 16'd7;
  localparam logic [15:0] FCS_LAST      = 16'd3;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  // Bit reversal, used to turn the normal polynomial into its LSB-first form.
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 next-state for one byte, LSB of the byte first.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  localparam logic [31:0] POLY_R = bitrev32(CRC32_POLY);

  logic [31:0] w_c;

  // Eight unrolled serial steps of the reflected LFSR.
  always_comb begin
    w_c = i_crc;
    for (int i = 0; i < 8; i++)
      w_c = (w_c >> 1) ^ ((w_c[0] ^ i_data[i]) ? POLY_R : 32'h0);
    o_crc = w_c;
  end

endmodule

// File: rtl/gmii_mac_tx.sv
// GMII transmit MAC: preamble/SFD, payload, zero pad, FCS, inter-frame gap.
// Underflow mid-frame aborts with one tx_er cycle and drains the rest.
module gmii_mac_tx
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES  = 12,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic       gmii_tx_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       frame_sent,
  output logic       frame_err
);

  localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  tx_state_e   r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [15:0] r_idx, w_idx_nxt;
  logic [31:0] r_crc, w_crc_nxt, w_crc_calc, w_fcs;
  logic [7:0]  w_crc_byte, w_fcs_byte;
  logic [7:0]  r_txd, w_txd_nxt;
  logic        r_en, r_er, r_sent, r_err;
  logic        w_en_nxt, w_er_nxt, w_sent_nxt, w_err_nxt;

  // Ready tracks state only, so upstream sees a stable value all cycle.
  assign tx_ready   = (r_state == S_SFD) || (r_state == S_DATA) || (r_state == S_DRAIN);
  assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_fcs      = ~r_crc;
  assign w_crc_byte = ((r_state == S_SFD) || (r_state == S_DATA)) ? tx_data : 8'h00;

  crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (w_crc_byte),
    .o_crc  (w_crc_calc)
  );

  // FCS goes out least-significant byte first.
  always_comb begin
    case (r_idx[1:0])
      2'd0:    w_fcs_byte = w_fcs[7:0];
      2'd1:    w_fcs_byte = w_fcs[15:8];
      2'd2:    w_fcs_byte = w_fcs[23:16];
      default: w_fcs_byte = w_fcs[31:24];
    endcase
  end

  // State register and registered GMII outputs; reset truncates any frame.
  always_ff @(posedge gmii_tx_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_crc   <= CRC32_INIT;
      r_txd   <= '0;
      r_en    <= 1'b0;
      r_er    <= 1'b0;
      r_sent  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_crc   <= w_crc_nxt;
      r_txd   <= w_txd_nxt;
      r_en    <= w_en_nxt;
      r_er    <= w_er_nxt;
      r_sent  <= w_sent_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next state plus byte/index counters.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE:
        if (tx_valid) begin
          w_state_nxt = S_PREAMBLE;
          w_idx_nxt   = 16'd1;
          w_cnt_nxt   = '0;
        end
      S_PREAMBLE:
        if (r_idx == PREAMBLE_LEN) w_state_nxt = S_SFD;
        else                       w_idx_nxt   = r_idx + 16'd1;
      S_SFD, S_DATA:
        if (!tx_valid) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (tx_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = (w_cnt_inc >= MIN_LEN) ? S_FCS : S_PAD;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      S_PAD: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_cnt_inc >= MIN_LEN) begin
          w_state_nxt = S_FCS;
          w_idx_nxt   = '0;
        end
      end
      S_FCS:
        if (r_idx == FCS_LAST) begin
          w_state_nxt = S_IFG;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 16'd1;
        end
      S_DRAIN:
        if (tx_valid && tx_last) begin
          w_state_nxt = S_IFG;
          w_idx_nxt   = '0;
        end
      S_IFG:
        if (r_idx >= IFG_LAST) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 16'd1;
        end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next GMII byte, pulses and CRC accumulation for the coming cycle.
  always_comb begin
    w_txd_nxt  = 8'h00;
    w_en_nxt   = 1'b0;
    w_er_nxt   = 1'b0;
    w_sent_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    w_crc_nxt  = r_crc;
    case (r_state)
      S_IDLE: begin
        w_crc_nxt = CRC32_INIT;
        if (tx_valid) begin
          w_txd_nxt = PREAMBLE_BYTE;
          w_en_nxt  = 1'b1;
        end
      end
      S_PREAMBLE: begin
        w_en_nxt  = 1'b1;
        w_txd_nxt = (r_idx == PREAMBLE_LEN) ? SFD_BYTE : PREAMBLE_BYTE;
      end
      S_SFD, S_DATA: begin
        w_en_nxt = 1'b1;
        if (tx_valid) begin
          w_txd_nxt = tx_data;
          w_crc_nxt = w_crc_calc;
        end else begin
          w_er_nxt  = 1'b1;
          w_err_nxt = 1'b1;
        end
      end
      S_PAD: begin
        w_en_nxt  = 1'b1;
        w_crc_nxt = w_crc_calc;
      end
      S_FCS: begin
        w_en_nxt   = 1'b1;
        w_txd_nxt  = w_fcs_byte;
        w_sent_nxt = (r_idx == FCS_LAST);
      end
      default: ;
    endcase
  end

  assign gmii_txd   = r_txd;
  assign gmii_tx_en = r_en;
  assign gmii_tx_er = r_er;
  assign frame_sent = r_sent;
  assign frame_err  = r_err;

endmodule
